// File: rtl/ldpc_msg_pkg.sv
// rtl/ldpc_msg_pkg.sv - LDPC message types and sign-magnitude helpers shared by check and variable nodes
package ldpc_msg_pkg;

    localparam int MSG_WIDTH = 6;
    localparam int POS_MAX   = 2 ** (MSG_WIDTH - 1) - 1;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } cn_state_t;

    // Negative zero folds to +0 so downstream never sees a signed zero.
    function automatic int sm_to_tc(input logic sgn, input int mag);
        return (sgn && (mag != 0)) ? -mag : mag;
    endfunction

endpackage

// File: rtl/cn_serial_minsum_if.sv
// rtl/cn_serial_minsum_if.sv - v2c input / c2v output handshake bundle of the serial check node
interface cn_serial_minsum_if
    import ldpc_msg_pkg::*;
#(
    parameter int MSG_WIDTH = ldpc_msg_pkg::MSG_WIDTH
);
    logic [MSG_WIDTH-1:0] i_v2c;
    logic                 i_valid;
    logic                 o_ready;
    logic [MSG_WIDTH-1:0] o_c2v;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_last;
    logic                 o_parity;

    modport slave (
        input  i_v2c, i_valid, i_ready,
        output o_ready, o_c2v, o_valid, o_last, o_parity
    );

    modport master (
        output i_v2c, i_valid, i_ready,
        input  o_ready, o_c2v, o_valid, o_last, o_parity
    );
endinterface

// File: rtl/cn_min2_tracker.sv
// rtl/cn_min2_tracker.sv - running first/second minimum and argmin of a magnitude stream
module cn_min2_tracker #(
    parameter int MAG_W = 5,
    parameter int IDX_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_init,
    input  logic             i_upd,
    input  logic [MAG_W-1:0] i_mag,
    input  logic [IDX_W-1:0] i_idx,
    output logic [MAG_W-1:0] o_min1,
    output logic [MAG_W-1:0] o_min2,
    output logic [IDX_W-1:0] o_idx,
    output logic [MAG_W-1:0] o_min1_nxt,
    output logic [MAG_W-1:0] o_min2_nxt,
    output logic [IDX_W-1:0] o_idx_nxt
);
    logic [MAG_W-1:0] min1_q, min1_d;
    logic [MAG_W-1:0] min2_q, min2_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Strict compares: a tie with min1 lands in min2 and the earlier index keeps idx.
    always_comb begin
        min1_d = min1_q;
        min2_d = min2_q;
        idx_d  = idx_q;
        if (i_init) begin
            min1_d = '1;
            min2_d = '1;
            idx_d  = '0;
        end else if (i_upd) begin
            if (i_mag < min1_q) begin
                min2_d = min1_q;
                min1_d = i_mag;
                idx_d  = i_idx;
            end else if (i_mag < min2_q) begin
                min2_d = i_mag;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            min1_q <= '1;
            min2_q <= '1;
            idx_q  <= '0;
        end else begin
            min1_q <= min1_d;
            min2_q <= min2_d;
            idx_q  <= idx_d;
        end
    end

    assign o_min1     = min1_q;
    assign o_min2     = min2_q;
    assign o_idx      = idx_q;
    assign o_min1_nxt = min1_d;
    assign o_min2_nxt = min2_d;
    assign o_idx_nxt  = idx_d;
endmodule

// File: rtl/cn_serial_minsum.sv
// rtl/cn_serial_minsum.sv - serial min-sum LDPC check node; CN_OFFSET_EN selects offset min-sum
module cn_serial_minsum
    import ldpc_msg_pkg::*;
#(
    parameter int MSG_WIDTH = ldpc_msg_pkg::MSG_WIDTH,
    parameter int ROW_DEG   = 6,
    parameter int OFFSET    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    cn_serial_minsum_if.slave     bus
);
    localparam int MAG_W = MSG_WIDTH - 1;
    localparam int IDX_W = $clog2(ROW_DEG);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(ROW_DEG - 1);

    cn_state_t            state_q, state_d;
    logic [IDX_W-1:0]     cnt_q, cnt_d;
    logic                 sign_acc_q, sign_acc_d;
    logic [ROW_DEG-1:0]   sign_buf_q, sign_buf_d;
    logic [MSG_WIDTH-1:0] c2v_q, c2v_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 parity_q, parity_d;

    logic                 trk_init, trk_upd;
    logic [MAG_W-1:0]     min1, min2, min1_nxt, min2_nxt;
    logic [IDX_W-1:0]     idx, idx_nxt;

    cn_min2_tracker #(.MAG_W(MAG_W), .IDX_W(IDX_W)) u_tracker (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_init     (trk_init),
        .i_upd      (trk_upd),
        .i_mag      (bus.i_v2c[MAG_W-1:0]),
        .i_idx      (cnt_q),
        .o_min1     (min1),
        .o_min2     (min2),
        .o_idx      (idx),
        .o_min1_nxt (min1_nxt),
        .o_min2_nxt (min2_nxt),
        .o_idx_nxt  (idx_nxt)
    );

`ifndef CN_OFFSET_EN
    logic unused_offset;
    assign unused_offset = ^OFFSET;
`endif

    function automatic logic [MSG_WIDTH-1:0] c2v_value(
        input logic [IDX_W-1:0] k,
        input logic [MAG_W-1:0] m1,
        input logic [MAG_W-1:0] m2,
        input logic [IDX_W-1:0] ix,
        input logic             sgn
    );
        logic [MAG_W-1:0] mag;
        int               tc;
        mag = (k == ix) ? m2 : m1;
`ifdef CN_OFFSET_EN
        mag = (mag > MAG_W'(OFFSET)) ? mag - MAG_W'(OFFSET) : '0;
`endif
        tc = sm_to_tc(sgn, int'(mag));
        return tc[MSG_WIDTH-1:0];
    endfunction

    // Output registers are loaded one cycle ahead, so the first c2v uses the tracker's next values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sign_acc_d = sign_acc_q;
        sign_buf_d = sign_buf_q;
        c2v_d      = c2v_q;
        valid_d    = valid_q;
        last_d     = last_q;
        parity_d   = parity_q;
        trk_init   = 1'b0;
        trk_upd    = 1'b0;
        case (state_q)
            COLLECT: begin
                if (bus.i_valid) begin
                    trk_upd           = 1'b1;
                    sign_buf_d[cnt_q] = bus.i_v2c[MSG_WIDTH-1];
                    sign_acc_d        = sign_acc_q ^ bus.i_v2c[MSG_WIDTH-1];
                    if (cnt_q == LAST) begin
                        cnt_d    = '0;
                        state_d  = EMIT;
                        parity_d = sign_acc_d;
                        valid_d  = 1'b1;
                        last_d   = 1'b0;
                        c2v_d    = c2v_value('0, min1_nxt, min2_nxt, idx_nxt,
                                             sign_acc_d ^ sign_buf_d[0]);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                if (bus.i_ready) begin
                    if (cnt_q == LAST) begin
                        state_d    = COLLECT;
                        cnt_d      = '0;
                        valid_d    = 1'b0;
                        last_d     = 1'b0;
                        c2v_d      = '0;
                        sign_acc_d = 1'b0;
                        trk_init   = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                        last_d = (cnt_d == LAST);
                        c2v_d  = c2v_value(cnt_d, min1, min2, idx,
                                           sign_acc_q ^ sign_buf_q[cnt_d]);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= COLLECT;
            cnt_q      <= '0;
            sign_acc_q <= 1'b0;
            sign_buf_q <= '0;
            c2v_q      <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            parity_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sign_acc_q <= sign_acc_d;
            sign_buf_q <= sign_buf_d;
            c2v_q      <= c2v_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            parity_q   <= parity_d;
        end
    end

    assign bus.o_ready  = (state_q == COLLECT);
    assign bus.o_c2v    = c2v_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_last   = last_q;
    assign bus.o_parity = parity_q;
endmodule

// File: tb/tb_cn_serial_minsum.sv
// tb/tb_cn_serial_minsum.sv - randomized self-checking bench for cn_serial_minsum against a per-edge min-sum model
module tb_cn_serial_minsum;
    localparam int W   = 6;
    localparam int D   = 6;
    localparam int OFS = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cn_serial_minsum_if #(.MSG_WIDTH(W)) bus ();

    cn_serial_minsum #(.MSG_WIDTH(W), .ROW_DEG(D), .OFFSET(OFS)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] row [D];

    // Each output is the min magnitude and sign product over all *other* edges of the row.
    function automatic logic [W-1:0] exp_c2v(input int k);
        int   m;
        logic s;
        m = 2 ** (W - 1) - 1;
        s = 1'b0;
        for (int j = 0; j < D; j++) begin
            if (j != k) begin
                if (int'(row[j][W-2:0]) < m) m = int'(row[j][W-2:0]);
                s ^= row[j][W-1];
            end
        end
`ifdef CN_OFFSET_EN
        m = (m > OFS) ? m - OFS : 0;
`endif
        if (s && m != 0) return W'((1 << W) - m);
        return W'(m);
    endfunction

    function automatic logic exp_parity();
        logic p;
        p = 1'b0;
        for (int j = 0; j < D; j++) p ^= row[j][W-1];
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input logic [W-1:0] a, b, c, d, e, f);
        row[0] = a; row[1] = b; row[2] = c; row[3] = d; row[4] = e; row[5] = f;
    endtask

    task automatic rand_row();
        for (int j = 0; j < D; j++) begin
            row[j] = W'($urandom_range(0, (1 << W) - 1));
            if ($urandom_range(0, 1) == 1) row[j][W-2:0] = (W-1)'($urandom_range(0, 6));
        end
    endtask

    task automatic send_msgs(input int n, input int gap_pct);
        for (int j = 0; j < n; j++) begin
            if (int'($urandom_range(0, 99)) < gap_pct) begin
                bus.i_valid = 1'b0;
                bus.i_v2c   = W'($urandom);
                repeat ($urandom_range(1, 3)) step();
            end
            bus.i_valid = 1'b1;
            bus.i_v2c   = row[j];
            n_vec++;
            if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
                n_err++;
                $display("FAIL collect_hs j=%0d got ready=%b valid=%b want ready=1 valid=0",
                         j, bus.o_ready, bus.o_valid);
            end
            step();
        end
        bus.i_valid = 1'b0;
    endtask

    task automatic recv_row(input int stall_pct, input int stall_k, input logic junk);
        logic [W-1:0] e;
        int           n;
        n_vec++;
        if (bus.o_parity !== exp_parity()) begin
            n_err++;
            $display("FAIL parity got %b want %b", bus.o_parity, exp_parity());
        end
        for (int k = 0; k < D; k++) begin
            e = exp_c2v(k);
            if (k == stall_k) n = 3;
            else n = (int'($urandom_range(0, 99)) < stall_pct) ? int'($urandom_range(1, 3)) : 0;
            bus.i_ready = 1'b0;
            for (int s = 0; s < n; s++) begin
                bus.i_valid = junk;
                bus.i_v2c   = W'($urandom);
                step();
                n_vec++;
                if (bus.o_valid !== 1'b1 || bus.o_c2v !== e || bus.o_ready !== 1'b0 ||
                    bus.o_last !== (k == D - 1)) begin
                    n_err++;
                    $display("FAIL stall_hold k=%0d got c2v=%h v=%b r=%b l=%b want c2v=%h v=1 r=0 l=%b",
                             k, bus.o_c2v, bus.o_valid, bus.o_ready, bus.o_last, e, k == D - 1);
                end
            end
            bus.i_ready = 1'b1;
            bus.i_valid = junk;
            n_vec++;
            if (bus.o_valid !== 1'b1 || bus.o_c2v !== e || bus.o_ready !== 1'b0 ||
                bus.o_last !== (k == D - 1)) begin
                n_err++;
                $display("FAIL emit k=%0d got c2v=%h v=%b r=%b l=%b want c2v=%h v=1 r=0 l=%b",
                         k, bus.o_c2v, bus.o_valid, bus.o_ready, bus.o_last, e, k == D - 1);
            end
            step();
        end
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b0;
        n_vec++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_last !== 1'b0) begin
            n_err++;
            $display("FAIL row_end got v=%b r=%b l=%b want v=0 r=1 l=0",
                     bus.o_valid, bus.o_ready, bus.o_last);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_vec++;
        if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_last !== 1'b0 ||
            bus.o_c2v !== '0 || bus.o_parity !== 1'b0) begin
            n_err++;
            $display("FAIL reset got r=%b v=%b l=%b c2v=%h p=%b want r=1 v=0 l=0 c2v=00 p=0",
                     bus.o_ready, bus.o_valid, bus.o_last, bus.o_c2v, bus.o_parity);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        set_row(6'd5, 6'd3, 6'd7, 6'd3, 6'd9, 6'd12);
        send_msgs(D, 0);
        recv_row(0, -1, 1'b0);
    endtask

    task automatic test_mixed();
        set_row(6'd10, 6'd2, 6'h28, 6'd4, 6'd6, 6'd31);
        send_msgs(D, 0);
        recv_row(0, -1, 1'b0);
    endtask

    task automatic test_backpressure();
        set_row(6'd10, 6'd2, 6'h28, 6'd4, 6'd6, 6'd31);
        send_msgs(D, 0);
        recv_row(0, 2, 1'b1);
    endtask

    task automatic test_zero();
        set_row(6'd4, 6'h20, 6'd4, 6'h00, 6'd4, 6'h04);
        send_msgs(D, 0);
        recv_row(0, -1, 1'b0);
        set_row(6'd1, 6'd5, 6'h27, 6'd9, 6'h23, 6'd6);
        send_msgs(D, 0);
        recv_row(0, -1, 1'b0);
    endtask

    task automatic test_reset_mid_row();
        rand_row();
        send_msgs(3, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_vec++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_parity !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset got v=%b r=%b p=%b want v=0 r=1 p=0",
                     bus.o_valid, bus.o_ready, bus.o_parity);
        end
        rand_row();
        send_msgs(D, 0);
        recv_row(0, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) begin
            rand_row();
            send_msgs(D, 0);
            recv_row(0, -1, 1'b0);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 40; r++) begin
            rand_row();
            send_msgs(D, 30);
            recv_row(30, -1, 1'b1);
        end
    endtask

    initial begin
        bus.i_v2c   = '0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        test_reset();
        test_basic();
        test_mixed();
        test_backpressure();
        test_zero();
        test_reset_mid_row();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
